// File: rtl/gpio_in_debounce.sv
// rtl/gpio_in_debounce.sv - GPIO input synchroniser, per-channel debouncer, edge pulses and sticky events
module gpio_in_debounce #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             clk_100mhz,
  input  logic             rst,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_state,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic [WIDTH-1:0] event_latched,
  input  logic [WIDTH-1:0] event_clear,
  output logic             any_event
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Synchroniser chain; stage 0 is the only flop that sees the raw pin.
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s;

  // Per-channel stable-time counters.
  logic [CNT_W-1:0] cnt [WIDTH];

  // differ: synchronised level disagrees with the accepted level.
  // accept: it has disagreed long enough to be taken as the new level.
  logic [WIDTH-1:0] differ;
  logic [WIDTH-1:0] accept;

  assign s = sync_q[SYNC_STAGES-1];

  // Shift raw pins through the synchroniser chain.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= gpio_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  // Decide per channel whether this edge completes a stable interval.
  always_comb begin
    differ = '0;
    accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      differ[i] = (s[i] != gpio_state[i]);
      accept[i] = differ[i] && (cnt[i] == CNT_LAST);
    end
  end

  // Count consecutive disagreeing cycles; any agreement restarts the count.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (!differ[i] || accept[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Update accepted levels and emit one-cycle direction pulses.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      gpio_state <= '0;
      rise_pulse <= '0;
      fall_pulse <= '0;
    end else begin
      gpio_state <= gpio_state ^ accept;
      rise_pulse <= accept & s;
      fall_pulse <= accept & ~s;
    end
  end

  // Sticky event flags; a new event beats a simultaneous clear.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      event_latched <= '0;
    end else begin
      event_latched <= accept | (event_latched & ~event_clear);
    end
  end

  // Summary flag, one cycle behind the sticky flags.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      any_event <= 1'b0;
    end else begin
      any_event <= |event_latched;
    end
  end

endmodule

// File: doc/gpio_in_debounce.md
Name: gpio_in_debounce

Overview:
Input-side GPIO block that captures external pins (buttons, jumpers, header inputs) into the 100 MHz fabric domain.
- Synchronises each pin, debounces it with a per-channel stable-time counter, and presents a clean level.
- Generates single-cycle rise/fall pulses on each accepted level change.
- Holds sticky event flags until software/logic clears them.
- Sits between the top-level input pins and user logic, as the receive-side counterpart of the GPIO pattern drivers.

Parameters:
WIDTH, 8, number of GPIO input channels
SYNC_STAGES, 2, flip-flop stages in each input synchroniser (>=2)
DEBOUNCE_CYCLES, 1_000_000, consecutive cycles a synchronised level must hold before acceptance (10 ms at 100 MHz; >=1)

Ports:
clk_100mhz  input  1  system clock, 100 MHz
rst  input  1  asynchronous, active-high reset
gpio_in  input  WIDTH  raw asynchronous pin levels
gpio_state  output  WIDTH  debounced level per channel
rise_pulse  output  WIDTH  1-cycle pulse when gpio_state goes 0->1
fall_pulse  output  WIDTH  1-cycle pulse when gpio_state goes 1->0
event_latched  output  WIDTH  sticky flag, set on any accepted change
event_clear  input  WIDTH  per-channel clear for event_latched, active-high, synchronous
any_event  output  1  registered OR of event_latched

Behaviour:
- Reset (async assert, sync use on next edge after release): all synchroniser flops, counters, gpio_state, rise_pulse, fall_pulse, event_latched, any_event = 0.
- Synchroniser: SYNC_STAGES-deep shift chain per bit, reset to 0. Its last stage is s[i].
- Counter: per channel, width $clog2(DEBOUNCE_CYCLES+1), unsigned. Each edge, per channel i:
  - s[i] == gpio_state[i]: cnt <= 0.
  - s[i] != gpio_state[i] and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - s[i] != gpio_state[i] and cnt == DEBOUNCE_CYCLES-1: gpio_state[i] <= s[i]; cnt <= 0; rise_pulse[i] or fall_pulse[i] <= 1 per direction.
  - Otherwise pulses <= 0.
- Latency: a clean step on gpio_in is reflected on gpio_state on the (SYNC_STAGES+DEBOUNCE_CYCLES)-th rising edge after the change. The pulse is asserted in the same cycle gpio_state changes.
- Glitch rejection: any return of s[i] to gpio_state[i] before acceptance clears cnt. Bounces shorter than DEBOUNCE_CYCLES never change the output; the count restarts from 0.
- DEBOUNCE_CYCLES == 1: gpio_state follows s with one cycle of delay; each transition still pulses.
- Pulse rules: at most one of rise_pulse[i]/fall_pulse[i] is high in a cycle. Minimum spacing between pulses on one channel is DEBOUNCE_CYCLES cycles.
- Event latch: event_latched[i] <= 1 on an accepted change. Otherwise it is cleared when event_clear[i] == 1. Simultaneous set and clear: set wins.
- any_event: registered OR of event_latched, so it lags event_latched by 1 cycle.
- Channels are fully independent; simultaneous changes on several channels are handled in parallel.
- Reset mid-count: the counter is discarded and gpio_state returns to 0. After release, an input held high is re-accepted after SYNC_STAGES+DEBOUNCE_CYCLES edges and produces a rise_pulse.

Test Plan:
(All with WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4.)
1. Reset: hold rst with gpio_in=4'hF; release -> all outputs 0 at release; gpio_state=4'hF on the 6th edge, rise_pulse=4'hF for exactly 1 cycle, event_latched=4'hF, any_event=1 one cycle later.
2. Clean step: gpio_in[0] 0->1 with the rest low -> gpio_state[0]=1 on the 6th edge after the change; rise_pulse=4'h1 for 1 cycle; no fall_pulse.
3. Bounce: toggle gpio_in[1] high for 3 cycles, low for 2, then high steadily -> no pulse during the bounce; gpio_state[1]=1 exactly 6 edges after the final rising transition.
4. Falling edge plus clear: with gpio_state[2]=1, drive gpio_in[2]=0 -> fall_pulse=4'h4 for 1 cycle. Assert event_clear=4'h4 in the same cycle the flag sets -> flag stays 1. Assert event_clear=4'h4 one cycle later -> event_latched[2]=0 next cycle, and any_event drops one cycle after that.
5. Parallel channels: gpio_in 4'h0->4'hA in a single cycle -> gpio_state=4'hA and rise_pulse=4'hA in the same cycle; channels 0 and 2 unaffected.
6. Reset mid-count: step gpio_in[3] high, assert rst after 3 edges, release with the input still high -> no pulse before reset; rise_pulse[3] on the 6th edge after release.
